// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 write-only register file feeding the PWM block.
// Frames are 16 bits MSB first: {write, addr[6:0], data[7:0]}.
module spi_reg_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;

  logic                   w_sclk_s;
  logic                   w_copi_s;
  logic                   w_ncs_s;
  logic                   w_sclk_rise;
  logic                   w_ncs_fall;
  logic                   w_ncs_rise;

  logic [1:0]             r_state;
  logic [1:0]             w_state_next;
  logic [15:0]            r_shift;
  logic [15:0]            w_shift_next;
  logic [4:0]             r_count;
  logic [4:0]             w_count_next;
  logic                   w_commit;

  logic [7:0]             r_en_out_lo;
  logic [7:0]             r_en_out_hi;
  logic [7:0]             r_en_pwm_lo;
  logic [7:0]             r_en_pwm_hi;
  logic [7:0]             r_duty;

  // ncs chain presets high so reset never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_prev <= w_sclk_s;
      r_ncs_prev  <= w_ncs_s;
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_count_next = r_count;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ncs_fall) begin
          w_shift_next = '0;
          w_count_next = '0;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ncs_rise) begin
          w_state_next = ST_COMMIT;
        end else if (w_sclk_rise && !w_ncs_s) begin
          // Keep shifting past 16 so the counter alone flags long frames.
          w_shift_next = {r_shift[14:0], w_copi_s};
          if (r_count != 5'd31) w_count_next = r_count + 5'd1;
        end
      end
      ST_COMMIT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_count <= w_count_next;
    end
  end

  assign w_commit = (r_state == ST_COMMIT) && (r_count == 5'd16) && r_shift[15] &&
                    (r_shift[14:8] <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_out_lo <= '0;
      r_en_out_hi <= '0;
      r_en_pwm_lo <= '0;
      r_en_pwm_hi <= '0;
      r_duty      <= '0;
    end else if (w_commit) begin
      case (r_shift[14:8])
        7'h00:   r_en_out_lo <= r_shift[7:0];
        7'h01:   r_en_out_hi <= r_shift[7:0];
        7'h02:   r_en_pwm_lo <= r_shift[7:0];
        7'h03:   r_en_pwm_hi <= r_shift[7:0];
        7'h04:   r_duty      <= r_shift[7:0];
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_en_out_lo;
  assign en_reg_out_15_8 = r_en_out_hi;
  assign en_reg_pwm_7_0  = r_en_pwm_lo;
  assign en_reg_pwm_15_8 = r_en_pwm_hi;
  assign pwm_duty_cycle  = r_duty;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed self-checking bench for spi_reg_peripheral; SPI driven at 10 clk per sclk period.
module tb_spi_reg_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;

  int n_cmp;
  int n_err;

  spi_reg_peripheral #(
    .SYNC_STAGES(2),
    .MAX_ADDR   (7'h04)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Order: {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}
  logic [39:0] w_all;
  assign w_all = {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
                  pwm_duty_cycle};

  // Shifts nbits of data MSB first; ncs is left to the caller.
  task automatic spi_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = data[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic spi_send(input logic [31:0] data, input int nbits);
    ncs = 1'b0;
    spi_bits(data, nbits);
    ncs = 1'b1;
  endtask

  // Four rising edges after ncs rose, sampled 1 time unit later.
  task automatic wait_commit();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sclk = 1'($urandom_range(0, 1));
      copi = 1'($urandom_range(0, 1));
      ncs  = 1'($urandom_range(0, 1));
    end
    #1;
    n_cmp++;
    if (w_all !== 40'h0) begin
      n_err++;
      $display("FAIL reset_during: got %h expected %h", w_all, 40'h0);
    end
    @(negedge clk);
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (w_all !== 40'h0) begin
      n_err++;
      $display("FAIL reset_after: got %h expected %h", w_all, 40'h0);
    end
  endtask

  task automatic test_single_write();
    spi_send(32'h80F0, 16);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (w_all !== 40'h0) begin
      n_err++;
      $display("FAIL single_early: got %h expected %h", w_all, 40'h0);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (w_all !== 40'hF0_00_00_00_00) begin
      n_err++;
      $display("FAIL single_write: got %h expected %h", w_all, 40'hF0_00_00_00_00);
    end
    @(negedge clk);
  endtask

  task automatic test_full_map();
    logic [15:0] frames [4];
    logic [39:0] expv   [4];
    frames = '{16'h8155, 16'h82AA, 16'h83FF, 16'h8480};
    expv   = '{40'hF0_55_00_00_00, 40'hF0_55_AA_00_00, 40'hF0_55_AA_FF_00, 40'hF0_55_AA_FF_80};
    for (int i = 0; i < 4; i++) begin
      spi_send({16'h0, frames[i]}, 16);
      wait_commit();
      n_cmp++;
      if (w_all !== expv[i]) begin
        n_err++;
        $display("FAIL full_map[%0d]: got %h expected %h", i, w_all, expv[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_discards();
    logic [31:0] frames [4];
    int          nbits  [4];
    frames = '{32'h04C3, 32'h8512, 32'h4033, 32'h08433};
    nbits  = '{16, 16, 15, 17};
    for (int i = 0; i < 4; i++) begin
      spi_send(frames[i], nbits[i]);
      wait_commit();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (w_all !== 40'hF0_55_AA_FF_80) begin
        n_err++;
        $display("FAIL discard[%0d]: got %h expected %h", i, w_all, 40'hF0_55_AA_FF_80);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    ncs = 1'b0;
    for (int i = 15; i >= 8; i--) begin
      copi = 1'(16'h8011 >> i);
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (w_all !== 40'h0) begin
      n_err++;
      $display("FAIL abort_reset: got %h expected %h", w_all, 40'h0);
    end
    @(negedge clk);
    ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    spi_send(32'h8022, 16);
    wait_commit();
    n_cmp++;
    if (w_all !== 40'h22_00_00_00_00) begin
      n_err++;
      $display("FAIL abort_rewrite: got %h expected %h", w_all, 40'h22_00_00_00_00);
    end
    @(negedge clk);
    copi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (w_all !== 40'h22_00_00_00_00) begin
      n_err++;
      $display("FAIL sclk_ncs_high: got %h expected %h", w_all, 40'h22_00_00_00_00);
    end
  endtask

  task automatic test_back_to_back();
    spi_send(32'h8401, 16);
    repeat (3) @(negedge clk);
    ncs = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (pwm_duty_cycle !== 8'h01) begin
      n_err++;
      $display("FAIL b2b_first: got %h expected %h", pwm_duty_cycle, 8'h01);
    end
    @(negedge clk);
    spi_bits(32'h84FE, 16);
    ncs = 1'b1;
    wait_commit();
    n_cmp++;
    if (w_all !== 40'h22_00_00_00_FE) begin
      n_err++;
      $display("FAIL b2b_second: got %h expected %h", w_all, 40'h22_00_00_00_FE);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    test_reset();
    test_single_write();
    test_full_map();
    test_discards();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
- SPI mode-0 write-only register peripheral that sits directly upstream of the PWM block inside tt_um_uwasic_onboarding_benjamin_dong.
- Receives 16-bit frames from an external controller on ui_in[2:0].
- Decodes a 7-bit address and commits 8-bit data into five control registers.
- The PWM block consumes these registers to enable outputs and set the duty cycle.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per SPI input (minimum 2).
- MAX_ADDR, 7'h04, highest valid register address; writes above it are discarded.

Ports:
- clk  input  1  system clock (10 MHz nominal).
- rst_n  input  1  asynchronous active-low reset.
- sclk  input  1  SPI clock (ui_in[0]); asynchronous to clk.
- copi  input  1  SPI controller-out data (ui_in[1]); asynchronous to clk.
- ncs  input  1  SPI chip select, active low (ui_in[2]); asynchronous to clk.
- en_reg_out_7_0  output  8  register 0x00, output enables for uo_out[7:0].
- en_reg_out_15_8  output  8  register 0x01, output enables for uio_out[7:0].
- en_reg_pwm_7_0  output  8  register 0x02, PWM mode select for uo_out[7:0].
- en_reg_pwm_15_8  output  8  register 0x03, PWM mode select for uio_out[7:0].
- pwm_duty_cycle  output  8  register 0x04; 0x00 = 0 %, 0xFF = 100 %.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all five outputs to 0x00.
  - Reset also clears the synchronisers (ncs chain preset to 1, others to 0), the shift register and the bit counter.
  - Reset asserted mid-frame aborts the frame with no register change.
- Synchronisation:
  - Each of sclk, copi and ncs passes through a SYNC_STAGES flop chain, plus one history flop for sclk and ncs.
  - Edges are detected on synchronised values only.
- SCLK timing requirement: the high and low phases must each be ≥ 3 clk periods. Faster SCLK is out of spec.
- Frame format, MSB first:
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
  - copi is sampled on synchronised sclk rising edges while synchronised ncs = 0.
- Receiver states:
  - IDLE: ncs high.
    - On a synchronised ncs falling edge, clear the shift register and bit counter, then go to SHIFT.
  - SHIFT:
    - Each sclk rising edge shifts copi into bit 0 of a 16-bit register and increments a 5-bit counter.
    - The counter saturates at 31; extra bits keep shifting, so the last 16 bits are retained.
    - sclk edges while ncs is high are ignored.
    - On a synchronised ncs rising edge, go to COMMIT.
  - COMMIT (single cycle): a write occurs only if all three hold:
    - counter == 16,
    - bit15 == 1,
    - address ≤ MAX_ADDR.
    - Otherwise the frame is discarded silently. Then return to IDLE.
- Commit rules:
  - Exactly one register is written per frame; the other registers hold.
  - Read frames (bit15 = 0) never modify state; copi data is don't-care.
  - Frames with counter ≠ 16 (short or long) are discarded.
- Latency: the addressed output takes the new value at the SYNC_STAGES+2 clk rising edge after ncs rises at the pin (4 edges at default). Outputs are registered and glitch-free.
- Back-to-back frames:
  - ncs may fall again as soon as 3 clk after rising.
  - A COMMIT and the next frame's ncs falling edge are never detected in the same cycle under that minimum.
- Output-valid rule: registers hold their value indefinitely between writes. No handshake to the PWM block; it samples the outputs every cycle.

Test Plan:
- Reset: rst_n low for 5 clk with random SPI activity -> all five outputs read 0x00; after release, outputs stay 0x00 with ncs held high.
- Single write: frame 0x80F0 (write, addr 0x00, data 0xF0), sclk period 10 clk -> en_reg_out_7_0 = 0xF0 within 4 clk of ncs rise; all other outputs unchanged.
- Full map: writes 0x8155, 0x82AA, 0x83FF, 0x8480 -> en_reg_out_15_8 = 0x55, en_reg_pwm_7_0 = 0xAA, en_reg_pwm_15_8 = 0xFF, pwm_duty_cycle = 0x80.
- Discards: each with all registers pre-loaded:
  - read frame 0x04C3 -> no change.
  - invalid address 0x8512 -> no change.
  - 15-bit frame -> no change.
  - 17-bit frame -> no change.
- Abort: assert rst_n low after 8 bits of frame 0x8011, release, send 0x8022 -> en_reg_out_7_0 = 0x22. sclk toggles with ncs high cause no change.
- Back-to-back: 0x8401 then 0x84FE with 3 clk ncs-high gap -> pwm_duty_cycle = 0x01, then 0xFE.
